// File: rtl/mul_sequencer_if.sv
// ============================================================================
// Module      : mul_sequencer_if
// Description : CPU-side handshake bundle for the multi-cycle multiply unit.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface mul_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       aluop;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             stall;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;

    modport master (
        output start, aluop, a, b,
        input  stall, busy, done, result
    );

    modport slave (
        input  start, aluop, a, b,
        output stall, busy, done, result
    );
endinterface

`default_nettype wire

// File: rtl/mul_sequencer.sv
// ============================================================================
// Module      : mul_sequencer
// Description : Radix-2 shift-add multiplier for mul/mulh/mulhu with CPU stall.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module mul_sequencer #(
    parameter int WIDTH = 32
) (
    input  wire logic      clk,
    input  wire logic      rst_n,
    mul_sequencer_if.slave bus
);

    localparam int c_CW = $clog2(WIDTH);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(WIDTH - 1);

    localparam logic [3:0] c_OP_MUL   = 4'b0101;
    localparam logic [3:0] c_OP_MULH  = 4'b0110;
    localparam logic [3:0] c_OP_MULHU = 4'b0111;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_CALC = 2'd1;
    localparam logic [1:0] c_FIX  = 2'd2;
    localparam logic [1:0] c_DONE = 2'd3;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [c_CW-1:0]    r_cnt;
    logic               r_busy;
    logic               r_hi;
    logic               r_neg;
    logic [WIDTH-1:0]   r_mcand;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_result;

    logic               w_valid;
    logic               w_is_mulh;
    logic               w_accept;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH-1:0]   w_addend;
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_acc_step;
    logic [2*WIDTH-1:0] w_prod;

    assign w_valid   = (bus.aluop == c_OP_MUL) || (bus.aluop == c_OP_MULH) ||
                       (bus.aluop == c_OP_MULHU);
    assign w_is_mulh = (bus.aluop == c_OP_MULH);
    assign w_accept  = (r_state == c_IDLE) && bus.start && w_valid;

    // Two's-complement magnitude; the most negative value maps onto itself,
    // which is the correct unsigned magnitude.
    assign w_abs_a = bus.a[WIDTH-1] ? -bus.a : bus.a;
    assign w_abs_b = bus.b[WIDTH-1] ? -bus.b : bus.b;

    // The multiplier lives in the low half of the accumulator and drains out
    // as the partial product shifts in; the sum keeps its carry bit.
    assign w_addend   = r_acc[0] ? r_mcand : '0;
    assign w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, w_addend};
    assign w_acc_step = {w_sum, r_acc[WIDTH-1:1]};
    assign w_prod     = r_neg ? -r_acc : r_acc;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: if (w_accept) w_state_nxt = c_CALC;
            c_CALC: if (r_cnt == c_LAST) w_state_nxt = c_FIX;
            c_FIX:  w_state_nxt = c_DONE;
            c_DONE: w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= c_IDLE;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_hi     <= 1'b0;
            r_neg    <= 1'b0;
            r_mcand  <= '0;
            r_acc    <= '0;
            r_result <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != c_IDLE);
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        r_hi    <= (bus.aluop != c_OP_MUL);
                        r_neg   <= w_is_mulh & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                        r_mcand <= w_is_mulh ? w_abs_a : bus.a;
                        r_acc   <= {{WIDTH{1'b0}}, (w_is_mulh ? w_abs_b : bus.b)};
                        r_cnt   <= '0;
                    end
                end
                c_CALC: begin
                    r_acc <= w_acc_step;
                    r_cnt <= r_cnt + c_CW'(1);
                end
                c_FIX: begin
                    r_result <= r_hi ? w_prod[2*WIDTH-1:WIDTH] : w_prod[WIDTH-1:0];
                end
                default: ;
            endcase
        end
    end

    // Stall is masked during reset so a held start cannot freeze the CPU.
    assign bus.stall  = rst_n && (w_accept || (r_state == c_CALC) || (r_state == c_FIX));
    assign bus.busy   = r_busy;
    assign bus.done   = (r_state == c_DONE);
    assign bus.result = r_result;

endmodule

`default_nettype wire
